// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing defaults, sync polarities and counter widths.
// Used by the timing generator and by the capture-side logic that feeds LOCK_IN.
package vga_timing_gen_pkg;

    localparam int H_CNT_W     = 10;
    localparam int V_CNT_W     = 10;
    localparam int FRAME_CNT_W = 6;

    // 640x480 @ 60 Hz with a 25.175 MHz pixel clock
    localparam int DEF_H_VISIBLE     = 640;
    localparam int DEF_H_FRONT_PORCH = 16;
    localparam int DEF_H_SYNC_PULSE  = 96;
    localparam int DEF_H_BACK_PORCH  = 48;
    localparam int DEF_H_TOTAL       = 800;

    localparam int DEF_V_VISIBLE     = 480;
    localparam int DEF_V_FRONT_PORCH = 10;
    localparam int DEF_V_SYNC_PULSE  = 2;
    localparam int DEF_V_BACK_PORCH  = 33;
    localparam int DEF_V_TOTAL       = 525;

    localparam logic DEF_HS_POL = 1'b0;
    localparam logic DEF_VS_POL = 1'b0;

    localparam int DEF_LOCK_LINE  = 12;
    localparam int DEF_FRAME_RATE = 60;

    // Wrap length for a line or frame; an inconsistent total falls back to the segment sum.
    function automatic int period_len(input int visible, input int front, input int sync,
                                      input int back, input int total);
        return (visible + front + sync + back == total) ? total : visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_counter.sv
// Wrap counter with optional load and a sync-window flag; one instance for H, one for V.
module sync_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int WIDTH      = H_CNT_W,
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT_PORCH,
    parameter int SYNC_LEN   = DEF_H_SYNC_PULSE
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             advance,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_last,
    output logic             in_sync
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] SYNC_LO = WIDTH'(SYNC_START);
    localparam logic [WIDTH-1:0] SYNC_HI = WIDTH'(SYNC_START + SYNC_LEN);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (advance) begin
            if (load) begin
                count_next = load_value;
            end else if (count_reg == LAST) begin
                count_next = '0;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count   = count_reg;
    assign at_last = (count_reg == LAST);
    assign in_sync = (count_reg >= SYNC_LO) && (count_reg < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered syncs, active-area coordinates,
// frame-start strobe, line re-alignment on LOCK_IN and a frame-rate toggle.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_VISIBLE     = DEF_H_VISIBLE,
    parameter int   H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int   H_SYNC_PULSE  = DEF_H_SYNC_PULSE,
    parameter int   H_BACK_PORCH  = DEF_H_BACK_PORCH,
    parameter int   H_TOTAL       = DEF_H_TOTAL,
    parameter int   V_VISIBLE     = DEF_V_VISIBLE,
    parameter int   V_FRONT_PORCH = DEF_V_FRONT_PORCH,
    parameter int   V_SYNC_PULSE  = DEF_V_SYNC_PULSE,
    parameter int   V_BACK_PORCH  = DEF_V_BACK_PORCH,
    parameter int   V_TOTAL       = DEF_V_TOTAL,
    parameter logic HS_POL        = DEF_HS_POL,
    parameter logic VS_POL        = DEF_VS_POL,
    parameter int   LOCK_LINE     = DEF_LOCK_LINE,
    parameter int   FRAME_RATE    = DEF_FRAME_RATE
) (
    input  logic       v_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       lock_in,
    output logic       v_hs,
    output logic       v_vs,
    output logic [9:0] v_x,
    output logic [8:0] v_y,
    output logic       v_visible,
    output logic       frame_start,
    output logic       locked,
    output logic       pulse_1hz
);

    localparam int H_LEN = period_len(H_VISIBLE, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH, H_TOTAL);
    localparam int V_LEN = period_len(V_VISIBLE, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH, V_TOTAL);

    localparam logic [H_CNT_W-1:0]     H_VIS_L    = H_CNT_W'(H_VISIBLE);
    localparam logic [V_CNT_W-1:0]     V_VIS_L    = V_CNT_W'(V_VISIBLE);
    localparam logic [V_CNT_W-1:0]     LOCK_L     = V_CNT_W'(LOCK_LINE);
    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_RATE - 1);

    logic [H_CNT_W-1:0]     h_count;
    logic [V_CNT_W-1:0]     v_count;
    logic [V_CNT_W-1:0]     v_inc;
    logic                   h_last, v_last, h_in_sync, v_in_sync;
    logic                   h_wrap, frame_wrap, lock_edge, load_lock, visible_now;
    logic                   lock_in_reg, lock_pending_reg, lock_pending_next;
    logic                   locked_reg, pulse_reg;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;
    logic                   hs_reg, vs_reg, visible_reg, frame_start_reg;
    logic [9:0]             x_reg;
    logic [8:0]             y_reg;

    sync_counter #(
        .WIDTH      (H_CNT_W),
        .TOTAL      (H_LEN),
        .SYNC_START (H_VISIBLE + H_FRONT_PORCH),
        .SYNC_LEN   (H_SYNC_PULSE)
    ) u_h_counter (
        .clk        (v_clk),
        .srst       (reset),
        .advance    (enable),
        .load       (1'b0),
        .load_value ('0),
        .count      (h_count),
        .at_last    (h_last),
        .in_sync    (h_in_sync)
    );

    sync_counter #(
        .WIDTH      (V_CNT_W),
        .TOTAL      (V_LEN),
        .SYNC_START (V_VISIBLE + V_FRONT_PORCH),
        .SYNC_LEN   (V_SYNC_PULSE)
    ) u_v_counter (
        .clk        (v_clk),
        .srst       (reset),
        .advance    (h_wrap),
        .load       (lock_pending_reg),
        .load_value (LOCK_L),
        .count      (v_count),
        .at_last    (v_last),
        .in_sync    (v_in_sync)
    );

    assign h_wrap      = enable & h_last;
    assign frame_wrap  = h_wrap & v_last;
    assign v_inc       = v_last ? '0 : v_count + 1'b1;
    assign lock_edge   = lock_in & ~lock_in_reg;
    assign load_lock   = h_wrap & lock_pending_reg;
    assign visible_now = enable && (h_count < H_VIS_L) && (v_count < V_VIS_L);

    // A pending request is consumed at the wrap; edges arriving meanwhile merge into it.
    assign lock_pending_next = lock_pending_reg ? ~h_wrap : lock_edge;

    always_ff @(posedge v_clk) begin
        if (reset) begin
            lock_in_reg      <= 1'b0;
            lock_pending_reg <= 1'b0;
            locked_reg       <= 1'b0;
            frame_cnt_reg    <= '0;
            pulse_reg        <= 1'b0;
            hs_reg           <= ~HS_POL;
            vs_reg           <= ~VS_POL;
            visible_reg      <= 1'b0;
            frame_start_reg  <= 1'b0;
            x_reg            <= '0;
            y_reg            <= '0;
        end else begin
            lock_in_reg      <= lock_in;
            lock_pending_reg <= lock_pending_next;
            if (load_lock) begin
                locked_reg <= (v_inc == LOCK_L);
            end
            if (frame_wrap) begin
                if (frame_cnt_reg == FRAME_LAST) begin
                    frame_cnt_reg <= '0;
                    pulse_reg     <= ~pulse_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
            // Output stage lags the counters by exactly one cycle.
            hs_reg          <= (enable && h_in_sync) ? HS_POL : ~HS_POL;
            vs_reg          <= (enable && v_in_sync) ? VS_POL : ~VS_POL;
            visible_reg     <= visible_now;
            x_reg           <= visible_now ? h_count : '0;
            y_reg           <= visible_now ? v_count[8:0] : '0;
            frame_start_reg <= enable && (h_count == '0) && (v_count == '0);
        end
    end

    assign v_hs        = hs_reg;
    assign v_vs        = vs_reg;
    assign v_x         = x_reg;
    assign v_y         = y_reg;
    assign v_visible   = visible_reg;
    assign frame_start = frame_start_reg;
    assign locked      = locked_reg;
    assign pulse_1hz   = pulse_reg;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): H_VISIBLE 640 active pixels; H_FRONT_PORCH 16; H_SYNC_PULSE 96; H_BACK_PORCH 48; H_TOTAL 800.
REQ-002 It SHALL also have: V_VISIBLE 480 active lines; V_FRONT_PORCH 10; V_SYNC_PULSE 2; V_BACK_PORCH 33; V_TOTAL 525; HS_POL 0 and VS_POL 0 (asserted sync level); LOCK_LINE 12 (line loaded on lock); FRAME_RATE 60.
REQ-003 V_CLK  in  1  pixel clock for the VGA output; the only clock.
REQ-004 RESET  in  1  reset, synchronous and active-high.
REQ-005 ENABLE  in  1  run enable.
REQ-006 LOCK_IN  in  1  frame-alignment strobe from the capture side; rising edge requests lock.
REQ-007 V_HS  out  1  horizontal sync.
REQ-008 V_VS  out  1  vertical sync.
REQ-009 V_X  out  10  active-pixel column.
REQ-010 V_Y  out  9  active-line row.
REQ-011 V_VISIBLE  out  1  active-region flag.
REQ-012 FRAME_START  out  1  one-cycle pulse at the first pixel of each frame.
REQ-013 LOCKED  out  1  high when the last lock request needed no correction.
REQ-014 PULSE_1HZ  out  1  toggles once every FRAME_RATE frames.

Function
REQ-015 Internal counters SHALL be H (10 bit, 0..H_TOTAL-1) and V (10 bit, 0..V_TOTAL-1); both advance only when ENABLE=1.
REQ-016 H SHALL increment every enabled cycle and wrap from H_TOTAL-1 to 0; at the wrap, V SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-017 Line order SHALL be visible, front porch, sync, back porch; frame order SHALL be the same for lines.
REQ-018 V_HS SHALL equal HS_POL iff H is in [H_VISIBLE+H_FRONT_PORCH, H_VISIBLE+H_FRONT_PORCH+H_SYNC_PULSE); otherwise it SHALL equal ~HS_POL.
REQ-019 V_VS SHALL equal VS_POL iff V is in [V_VISIBLE+V_FRONT_PORCH, V_VISIBLE+V_FRONT_PORCH+V_SYNC_PULSE); otherwise it SHALL equal ~VS_POL.
REQ-020 V_VISIBLE SHALL be 1 iff ENABLE=1, H<H_VISIBLE and V<V_VISIBLE.
REQ-021 V_X and V_Y SHALL equal H[9:0] and V[8:0] when V_VISIBLE=1, and 0 otherwise.
REQ-022 All outputs SHALL be registered; outputs for counter state (H,V) SHALL appear exactly 1 cycle after that state, so V_HS, V_VS, V_X, V_Y and V_VISIBLE stay mutually aligned.
REQ-023 FRAME_START SHALL pulse for 1 cycle when the registered outputs show H=0, V=0 with ENABLE=1.
REQ-024 A 6-bit frame counter SHALL increment on each frame wrap (V from V_TOTAL-1 to 0).
REQ-025 At frame-counter value FRAME_RATE-1, the frame counter SHALL clear and PULSE_1HZ SHALL toggle.
REQ-026 LOCK_IN SHALL be registered once; a rising edge (current 1, previous 0) SHALL set lock_pending.
REQ-027 At the next H wrap with lock_pending=1, V SHALL load LOCK_LINE instead of V+1, and lock_pending SHALL clear.
REQ-028 On that load, LOCKED SHALL become 1 if V+1 (with wrap) already equalled LOCK_LINE, and 0 otherwise.
REQ-029 A LOCK_IN edge in the same cycle as the H wrap SHALL be serviced at the following wrap; further edges while lock is pending SHALL merge into one request.
REQ-030 While ENABLE=0: H, V, the frame counter and PULSE_1HZ SHALL hold; V_HS=~HS_POL, V_VS=~VS_POL, V_VISIBLE=0, FRAME_START=0; lock edges SHALL still be captured into lock_pending.

Reset
REQ-031 While RESET=1 the module SHALL set H=0, V=0, frame counter=0, lock_pending=0 and LOCK_IN history=0.
REQ-032 While RESET=1 the outputs SHALL be V_HS=~HS_POL, V_VS=~VS_POL, V_X=0, V_Y=0, V_VISIBLE=0, FRAME_START=0, LOCKED=0, PULSE_1HZ=0.
REQ-033 RESET SHALL override ENABLE and LOCK_IN, including mid-line and mid-frame.
REQ-034 On the first enabled cycle after reset, the counters SHALL be at H=0, V=0, and FRAME_START SHALL pulse 1 cycle later.

Structure
REQ-035 A shared package SHALL hold the default timing constants, sync polarities and the H/V counter widths; the capture-side counter uses the same package.
REQ-036 A single sub-module, sync_counter, SHALL implement one parameterised wrap counter with a sync-window compare, instantiated once for H and once for V; all other logic SHALL be top-level.

Verification
REQ-037 After reset, run 2 frames with ENABLE=1 -> V_HS low for exactly 96 of every 800 cycles, starting at X-count 656; V_VS low for exactly 2 lines starting at line 490; 640x480 V_VISIBLE cycles per frame.
REQ-038 Run 120 frames -> PULSE_1HZ toggles at frame 60 and again at frame 120; FRAME_START pulses 120 times, each 420000 cycles apart.
REQ-039 Apply a LOCK_IN edge with V=100 -> next line shows V=12, LOCKED=0; a second edge exactly one frame later -> LOCKED=1 and no change to V.
REQ-040 Deassert ENABLE at H=300, V=200 for 50 cycles -> outputs idle per REQ-030, then resume at H=300, V=200 with no skipped count.
REQ-041 Assert RESET mid-frame at H=700 (inside the sync pulse) -> next cycle V_HS=1, V_VISIBLE=0; after release, FRAME_START pulses on the 2nd cycle.
REQ-042 Apply 3 LOCK_IN edges within one line, one of them coinciding with the H wrap -> exactly one V load occurs, at the wrap that follows.
